cdc_tx_queue: RTL and testbench
===============================

// Module: cdc_tx_queue
// PURPOSE
//  Source-domain staging queue that sits directly upstream of the CDC synchronizer.
//  Buffers a burst of producer words and drains them one at a time into the
//  synchronizer's src_data/src_valid/src_ready port.
//  Enforces a programmable minimum idle gap between issued words so that pulse-type
//  crossings never see back-to-back events. Handshake-type crossings are
//  throttled by src_ready.
//  Single clock domain: the synchronizer's source clock.
// PARAMETERS
//  DATA_WIDTH  8  width of each queued word
//  DEPTH       4  queue entries; power of 2, >= 2
//  MIN_GAP     0  idle cycles forced after each issued word (0 = back-to-back allowed)
// PORTS
//  clk         in   1                   source-domain clock
//  rst         in   1                   synchronous reset, active-high
//  flush       in   1                   synchronous queue clear
//  in_data     in   DATA_WIDTH          producer word
//  in_valid    in   1                   producer word valid
//  in_ready    out  1                   queue can accept (not full)
//  out_data    out  DATA_WIDTH          word to synchronizer src_data
//  out_valid   out  1                   word to synchronizer src_valid
//  out_ready   in   1                   from synchronizer src_ready
//  level       out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset and flush state: pointers = 0, gap counter = 0, state = ISSUE.
//    Resulting outputs: level = 0, in_ready = 1, out_valid = 0. out_data = don't-care.
//  - Storage: DEPTH-entry array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    Wrap-around is the natural modulo of the pointer width.
//    - full  = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal)
//    - empty = (wr_ptr == rd_ptr)
//    - level = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1)
//  - Push when in_valid && in_ready, with in_ready = !full.
//    No write-through when full, even if a pop happens in the same cycle.
//  - Pop when out_valid && out_ready.
//    - out_valid = !empty && (state == ISSUE).
//    - out_data  = mem[rd_ptr] (combinational read). It is held stable while out_valid && !out_ready.
//  - Latency: a word pushed into an empty queue in cycle N is presented with out_valid = 1 in cycle N+1.
//    There is no bypass path.
//  - Simultaneous push and pop in the same cycle: level is unchanged. This is legal at any level except full, where push is blocked.
//  - Gap FSM, 2 states:
//    - ISSUE: on a pop with MIN_GAP > 0, load gap_cnt = MIN_GAP and go to GAP. With MIN_GAP = 0, stay in ISSUE.
//    - GAP: out_valid is forced to 0. gap_cnt decrements each cycle; when gap_cnt == 1, go to ISSUE.
//    - Result: with a continuously asserted out_ready, issued words are spaced exactly MIN_GAP+1 cycles apart.
//    - Pushes continue during GAP.
//  - out_valid never drops without a pop, except on flush or rst.
//  - flush: same effect as reset on pointers and FSM, and takes priority over any push or pop in the same cycle.
//    The data array is not cleared.
//  - rst takes priority over flush.
//  - Reset or flush mid-stream discards all queued words, and a word offered that cycle is not accepted.
//  - Arithmetic on gap_cnt is $clog2(MIN_GAP+1) bits wide (minimum 1), unsigned, with no wrap.
// TESTING
//  - Reset: assert rst 3 cycles with in_valid = 1 -> level = 0, in_ready = 1, out_valid = 0 throughout and 1 cycle after deassert.
//  - Latency: push 8'hA5 at cycle N, out_ready = 1 -> out_valid = 1 with out_data = 8'hA5 at N+1, level back to 0 at N+2.
//  - Full: DEPTH = 4, out_ready = 0, push 8'h01..8'h05 -> level = 4, in_ready = 0, 8'h05 is not accepted.
//    Then release out_ready -> 01, 02, 03, 04 are issued in order.
//  - Gap: MIN_GAP = 2, 3 words queued, out_ready = 1 -> out_valid pulses at cycles T, T+3, T+6, each pulse 1 cycle wide.
//  - Simultaneous: level = 2, push and pop in the same cycle -> level stays 2 and FIFO order is preserved.
//    At level = 4, pop with in_valid = 1 -> no push; level = 3.
//  - Flush: level = 3 plus push and pop in the same cycle as flush -> next cycle level = 0, out_valid = 0.
//    A subsequent push of 8'h3C is output next.

Source files
------------

// File: rtl/cdc_tx_queue.sv
// cdc_tx_queue: source-side staging FIFO feeding a CDC synchronizer, with a programmable idle gap between issued words
module cdc_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int MIN_GAP    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = MIN_GAP > 0 ? $clog2(MIN_GAP + 1) : 1;
  typedef enum logic {ISSUE, GAP} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic full, empty, push, pop;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = wr_ptr == rd_ptr;
  assign in_ready  = !full;
  assign out_valid = !empty && (state == ISSUE);
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = wr_ptr - rd_ptr;
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    if (state == ISSUE) begin
      if (pop && MIN_GAP > 0) begin
        state_nxt = GAP;
        gap_nxt   = GW'(MIN_GAP);
      end
    end else begin
      gap_nxt   = gap_cnt - GW'(1);
      state_nxt = gap_cnt == GW'(1) ? ISSUE : GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      gap_cnt <= '0;
      state   <= ISSUE;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      gap_cnt <= gap_nxt;
      state   <= state_nxt;
    end
  end
  always_ff @(posedge clk)
    if (push && !rst && !flush) mem[wr_ptr[AW-1:0]] <= in_data;
endmodule

// File: tb/tb_cdc_tx_queue.sv
// tb_cdc_tx_queue: directed checks of cdc_tx_queue with MIN_GAP=0 (dut) and MIN_GAP=2 (dut_g)
module tb_cdc_tx_queue;
  logic clk = 0, rst = 1, flush = 0;
  logic [7:0] in_data = 0, out_data, g_in_data = 0, g_out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic g_in_valid = 0, g_in_ready, g_out_valid, g_out_ready = 0;
  logic [2:0] level, g_level;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cdc_tx_queue #(.DATA_WIDTH(8), .DEPTH(4), .MIN_GAP(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level));
  cdc_tx_queue #(.DATA_WIDTH(8), .DEPTH(4), .MIN_GAP(2)) dut_g (
    .clk(clk), .rst(rst), .flush(1'b0), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .out_data(g_out_data), .out_valid(g_out_valid),
    .out_ready(g_out_ready), .level(g_level));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    in_data = d;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask
  initial begin
    in_valid = 1;
    in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_level", 32'(level), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
    end
    chk("rst_g_level", 32'(g_level), 0);
    rst = 0;
    in_valid = 0;
    tick();
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    out_ready = 1;
    push(8'hA5);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_data", 32'(out_data), 32'hA5);
    chk("lat_level_n1", 32'(level), 1);
    tick();
    chk("lat_level_n2", 32'(level), 0);
    chk("lat_out_valid_n2", 32'(out_valid), 0);
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    in_data = 8'h05;
    in_valid = 1;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_level", 32'(level), 4);
    tick();
    in_valid = 0;
    chk("full_level_after5", 32'(level), 4);
    chk("full_hold_valid", 32'(out_valid), 1);
    chk("full_hold_data", 32'(out_data), 1);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_drain_valid", 32'(out_valid), 1);
      chk("full_drain_data", 32'(out_data), 32'(i));
      tick();
    end
    chk("full_no_05", 32'(out_valid), 0);
    chk("full_empty_level", 32'(level), 0);
    out_ready = 0;
    push(8'h11);
    push(8'h22);
    chk("sim_level2", 32'(level), 2);
    in_data = 8'h33;
    in_valid = 1;
    out_ready = 1;
    #1;
    chk("sim_pop_data", 32'(out_data), 32'h11);
    tick();
    in_valid = 0;
    chk("sim_level_kept", 32'(level), 2);
    chk("sim_order1", 32'(out_data), 32'h22);
    tick();
    chk("sim_order2", 32'(out_data), 32'h33);
    tick();
    chk("sim_drained", 32'(level), 0);
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(8'h40 + 8'(i));
    in_data = 8'h55;
    in_valid = 1;
    out_ready = 1;
    #1;
    chk("fullpop_in_ready", 32'(in_ready), 0);
    chk("fullpop_data", 32'(out_data), 32'h41);
    tick();
    in_valid = 0;
    chk("fullpop_level", 32'(level), 3);
    for (int i = 2; i <= 4; i++) begin
      chk("fullpop_drain", 32'(out_data), 32'h40 + 32'(i));
      tick();
    end
    chk("fullpop_no_55", 32'(level), 0);
    out_ready = 0;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    chk("flush_level3", 32'(level), 3);
    flush = 1;
    in_data = 8'h64;
    in_valid = 1;
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_level", 32'(level), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    push(8'h3C);
    chk("flush_next_valid", 32'(out_valid), 1);
    chk("flush_next_data", 32'(out_data), 32'h3C);
    tick();
    chk("flush_final_level", 32'(level), 0);
    for (int i = 1; i <= 3; i++) begin
      g_in_data = 8'h70 + 8'(i);
      g_in_valid = 1;
      tick();
    end
    g_in_valid = 0;
    chk("gap_level3", 32'(g_level), 3);
    chk("gap_hold_valid", 32'(g_out_valid), 1);
    g_out_ready = 1;
    for (int c = 0; c < 9; c++) begin
      chk("gap_valid", 32'(g_out_valid), (c % 3 == 0 && c < 9) ? 1 : 0);
      if (c % 3 == 0) chk("gap_data", 32'(g_out_data), 32'h71 + 32'(c / 3));
      tick();
    end
    chk("gap_level_end", 32'(g_level), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
